// File: rtl/sine_voice_scheduler_pkg.sv
// Shared types and helpers for the multi-voice sine scheduler.
package sine_voice_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PHASE,
        LOOKUP,
        ACC,
        DONE
    } voice_state_e;

    function automatic int log2Voices(input int voices);
        int bits;
        bits = 0;
        while ((1 << bits) < voices) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table with one registered read port; entry i holds
// round((2^(BITSIZE-1)-1) * sin(pi/2 * i/(DEPTH-1))), built at elaboration.
module quarter_sine_rom #(
    parameter int BITSIZE   = 24,
    parameter int TABLESIZE = 9
) (
    input  logic                 clk,
    input  logic [TABLESIZE-1:0] addr,
    output logic [BITSIZE-1:0]   data
);

    localparam int DEPTH = 1 << TABLESIZE;

    // Taylor series in Q30 fixed point; nine terms keep the error far below one LSB.
    function automatic logic [BITSIZE-1:0] sineEntry(input int idx);
        longint x, x2, term, sum, amp, val;
        amp  = (longint'(1) << (BITSIZE - 1)) - 1;
        x    = (longint'(idx) * 64'sd3373259426) / longint'(2 * (DEPTH - 1));
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 9; k++) begin
            term = -(((term * x2) >>> 30) / longint'(2 * k * (2 * k + 1)));
            sum  = sum + term;
        end
        val = (sum * amp + (longint'(1) << 29)) >>> 30;
        if (val > amp) val = amp;
        if (val < 0)   val = 0;
        return val[BITSIZE-1:0];
    endfunction

    logic [BITSIZE-1:0] romTable [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : gEntry
        assign romTable[i] = sineEntry(i);
    end

    always_ff @(posedge clk) begin
        data <= romTable[addr];
    end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one quarter-wave sine ROM across VOICES oscillators and
// mixes them into one signed sample per lrclk rising edge.
module sine_voice_scheduler
    import sine_voice_scheduler_pkg::*;
#(
    parameter int BITSIZE   = 24,
    parameter int PHASESIZE = 16,
    parameter int TABLESIZE = 9,
    parameter int VOICES    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          lrclk,
    input  logic                          cfg_we,
    input  logic [log2Voices(VOICES)-1:0] cfg_addr,
    input  logic [PHASESIZE-1:0]          cfg_freq,
    input  logic                          cfg_en,
    input  logic                          cfg_phase_clr,
    output logic [BITSIZE-1:0]            out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int VW   = log2Voices(VOICES);
    localparam int ACCW = BITSIZE + VW;

    voice_state_e state, nextState;

    logic [2:0]                  lrSync;
    logic                        start;
    logic [PHASESIZE-1:0]        phase [VOICES];
    logic [PHASESIZE-1:0]        freq  [VOICES];
    logic [VOICES-1:0]           en;
    logic [VW-1:0]               voice;
    logic [PHASESIZE-1:0]        phaseSum;
    logic [TABLESIZE+1:0]        lookupBits;
    logic [TABLESIZE-1:0]        romAddr;
    logic [BITSIZE-1:0]          romData;
    logic signed [ACCW-1:0]      romExt;
    logic                        signReg;
    logic signed [ACCW-1:0]      acc;

    // Two synchronizer stages followed by the edge register.
    always_ff @(posedge clk) begin
        if (reset) lrSync <= '0;
        else       lrSync <= {lrSync[1:0], lrclk};
    end

    assign start    = lrSync[1] & ~lrSync[2];
    assign busy     = (state != IDLE);
    assign phaseSum = phase[voice] + freq[voice];
    assign romAddr  = lookupBits[TABLESIZE] ? ~lookupBits[TABLESIZE-1:0]
                                            :  lookupBits[TABLESIZE-1:0];
    assign romExt   = {{VW{romData[BITSIZE-1]}}, romData};

    quarter_sine_rom #(
        .BITSIZE  (BITSIZE),
        .TABLESIZE(TABLESIZE)
    ) uRom (
        .clk (clk),
        .addr(romAddr),
        .data(romData)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = PHASE;
            PHASE:   nextState = LOOKUP;
            LOOKUP:  nextState = ACC;
            ACC:     nextState = (voice == VW'(VOICES - 1)) ? DONE : PHASE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Config writes come last so a phase clear overrides the PHASE-state increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            voice      <= '0;
            acc        <= '0;
            lookupBits <= '0;
            signReg    <= 1'b0;
            out        <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            en         <= '0;
            for (int i = 0; i < VOICES; i++) begin
                phase[i] <= '0;
                freq[i]  <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (start && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        voice <= '0;
                        acc   <= '0;
                    end
                end
                PHASE: begin
                    phase[voice] <= phaseSum;
                    lookupBits   <= phaseSum[PHASESIZE-1 -: TABLESIZE+2];
                end
                LOOKUP: begin
                    signReg <= lookupBits[TABLESIZE+1];
                end
                ACC: begin
                    if (en[voice]) acc <= signReg ? acc - romExt : acc + romExt;
                    if (voice != VW'(VOICES - 1)) voice <= voice + VW'(1);
                end
                DONE: begin
                    out       <= acc[VW +: BITSIZE];
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
            if (cfg_we) begin
                freq[cfg_addr] <= cfg_freq;
                en[cfg_addr]   <= cfg_en;
                if (cfg_phase_clr) phase[cfg_addr] <= '0;
            end
        end
    end

endmodule
